dkong_inport_gen: RTL and testbench
===================================

# dkong_inport_gen

Parametrised input-port block for the CPU read bus. Replaces the fixed four-port wired-OR input mux with a configurable number of ports. It adds:

- two-flop synchronisation and per-bit debouncing of raw switch inputs;
- per-port polarity selection;
- a sticky coin latch that holds a coin insertion until the CPU has read it.

It sits between the board switch/DIP inputs and the CPU data-in mux, with one active-low output enable per port coming from the address decoder.

## Interface
Parameters:
- NPORT, 4, number of input ports.
- W, 8, port width in bits.
- INV, 4'b0111, per-port polarity. Bit p = 1 means port p is active-low (inverted on read). Bit p = 0 means port p passes straight through (DIP).
- DB_TICKS, 4, consecutive I_TICK samples needed to accept a new level. 0 bypasses the debounce stage.
- COIN_PORT, 2, port holding the coin bit.
- COIN_BIT, 7, bit position of coin within COIN_PORT.

Ports:
- I_CLK, in, 1, system clock.
- I_RST_n, in, 1. Reset is asynchronous and active-low.
- I_TICK, in, 1, debounce sample strobe, one I_CLK wide (typically derived from vblank or a ~1 kHz divider).
- I_SW, in, NPORT*W, raw inputs. Port p occupies bits [p*W +: W]. Asynchronous to I_CLK.
- I_OE_n, in, NPORT, per-port read enable, active low.
- O_D, out, W, read data.
- O_COIN, out, 1, coin pending (latched, not yet read).

## Operation
Input path, per bit:
- Two-flop synchroniser produces `sync`.
- The debouncer holds `stable` and a counter `cnt` of width clog2(DB_TICKS+1).
- When `sync == stable`: cnt <= 0.
- Else, on each I_TICK: cnt <= cnt+1. When cnt reaches DB_TICKS-1 on a tick, stable <= sync and cnt <= 0.
- Any bounce back to `stable` before acceptance clears cnt.
- DB_TICKS = 0: stable <= sync every clock.

Per-port value:
- val[p] = INV[p] ? ~stable[p] : stable[p].

Coin latch:
- `coin_act` = val[COIN_PORT][COIN_BIT].
- A rising edge of coin_act (registered previous value) sets `coin_lat`.
- coin_lat clears on the rising edge of I_OE_n[COIN_PORT], i.e. at the end of the read, never mid-read.
- If set and clear occur in the same cycle, set wins.
- O_COIN = coin_lat.

Read mux:
- O_D = OR over p of (I_OE_n[p] ? 0 : rd[p]).
- rd[p] = val[p], except that rd[COIN_PORT][COIN_BIT] = coin_lat | coin_act.
- Multiple enables low at once: the port values are ORed, no error.
- No enable low: O_D = 0.
- The read mux is combinational from registers and I_OE_n; there is no register on O_D.

Reset values:
- `stable` resets to all 1s for ports with INV=1 and all 0s for ports with INV=0, so every val is 0.
- cnt = 0, synchronisers = reset value of stable, coin_lat = 0, previous coin_act = 0, previous I_OE_n = all 1s.
- Result: O_D = 0 and O_COIN = 0 in reset.
- Reset asserted mid-debounce discards the pending count; reset mid-read discards coin_lat.

## Timing
- Input change to `stable`: 2 I_CLK synchroniser cycles, then DB_TICKS I_TICK strobes, plus ≤1 I_CLK.
- DB_TICKS = 0: input change to O_D is 3 I_CLK.
- I_OE_n to O_D is combinational, same cycle.
- Coin edge to O_COIN: 1 I_CLK after coin_act rises.
- Coin clear: coin_lat is 0 one I_CLK after I_OE_n[COIN_PORT] rises.
- I_TICK asserted on consecutive clocks counts as multiple ticks.

## Structure
- Package `dkong_inport_pkg`:
  - default constants for NPORT, W, DB_TICKS, COIN_PORT, COIN_BIT;
  - a function computing the reset vector for `stable` from INV.
- Sub-module `dkong_debounce`: parametrised vector (width W, DB_TICKS, reset value). Contains the synchroniser, per-bit counters and the stable register. Instantiated NPORT times through a generate loop.
- The top level holds the polarity logic, coin latch and read OR.
- Target size: 150–250 lines total.

## Test plan
1. **Reset:** hold I_RST_n low, all I_SW = 1, all I_OE_n = 0. Expect O_D = 8'h00, O_COIN = 0. Release reset with I_SW port0 = 8'hFE. After 2 clk + 4 ticks, with I_OE_n = 4'b1110, expect O_D = 8'h01.
2. **Bounce rejection:** toggle port1 bit4 low for 3 ticks, then high, repeatedly. Expect O_D bit4 never set on port1 read. Hold low for 4 ticks: expect bit4 = 1 after the 4th tick.
3. **Polarity:** INV[3] = 0, I_SW port3 = 8'h5A, read port3. Expect O_D = 8'h5A. Same data on port0 (INV = 1) reads 8'hA5.
4. **Coin latch:** pulse coin low for 5 ticks, then release before any read. Expect O_COIN = 1 and a port2 read returning bit7 = 1. On I_OE_n[2] rising, expect O_COIN = 0 next clk and the next read returning bit7 = 0.
5. **Simultaneous set/clear:** a new coin edge in the same cycle as I_OE_n[2] rising. Expect O_COIN stays 1.
6. **Multi-enable:** port0 val 8'h03, port1 val 8'h30, I_OE_n = 4'b1100. Expect O_D = 8'h33. With I_OE_n = 4'b1111, expect O_D = 8'h00.

Source files
------------

// File: rtl/dkong_inport_pkg.sv
// Shared constants and helpers for the Donkey Kong input-port block.
// Holds the default geometry and the reset-vector builder for the debouncers.
package dkong_inport_pkg;

    localparam int NPORT_DEF     = 4;
    localparam int W_DEF         = 8;
    localparam int DB_TICKS_DEF  = 4;
    localparam int COIN_PORT_DEF = 2;
    localparam int COIN_BIT_DEF  = 7;
    localparam logic [3:0] INV_DEF = 4'b0111;

    // Widest port bus the reset-vector helper can describe (NPORT*W).
    localparam int MAX_BITS = 256;

    // Active-low ports idle at all 1s so every polarity-corrected value resets to 0.
    function automatic logic [MAX_BITS-1:0] stable_rst(input logic [31:0] inv,
                                                       input int nport,
                                                       input int w);
        logic [MAX_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i < nport * w) r[i] = inv[i / w];
        end
        return r;
    endfunction

endpackage

// File: rtl/dkong_debounce.sv
// Two-flop synchroniser plus per-bit tick-counting debouncer for one input port.
// A new level is accepted only after DB_TICKS consecutive ticks at that level.
module dkong_debounce
    import dkong_inport_pkg::*;
#(
    parameter int             W        = W_DEF,
    parameter int             DB_TICKS = DB_TICKS_DEF,
    parameter logic [W-1:0]   RST_VAL  = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic [W-1:0] sw,
    output logic [W-1:0] stable
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
        end else begin
            meta <= sw;
            sync <= meta;
        end
    end

    generate
        if (DB_TICKS == 0) begin : g_bypass
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) stable <= RST_VAL;
                else        stable <= sync;
            end
        end else begin : g_db
            localparam int            CW   = $clog2(DB_TICKS + 1);
            localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

            for (genvar i = 0; i < W; i++) begin : g_bit
                logic [CW-1:0] cnt;
                logic          stable_q;

                // Any sample matching the held level restarts the count.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt      <= '0;
                        stable_q <= RST_VAL[i];
                    end else if (sync[i] == stable_q) begin
                        cnt <= '0;
                    end else if (tick) begin
                        if (cnt == LAST) begin
                            stable_q <= sync[i];
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                assign stable[i] = stable_q;
            end
        end
    endgenerate

endmodule

// File: rtl/dkong_inport_gen.sv
// Configurable CPU input-port block: debounced switches, per-port polarity,
// sticky coin latch and a wired-OR read mux driven by active-low enables.
module dkong_inport_gen
    import dkong_inport_pkg::*;
#(
    parameter int               NPORT     = NPORT_DEF,
    parameter int               W         = W_DEF,
    parameter logic [NPORT-1:0] INV       = NPORT'(INV_DEF),
    parameter int               DB_TICKS  = DB_TICKS_DEF,
    parameter int               COIN_PORT = COIN_PORT_DEF,
    parameter int               COIN_BIT  = COIN_BIT_DEF
) (
    input  logic               I_CLK,
    input  logic               I_RST_n,
    input  logic               I_TICK,
    input  logic [NPORT*W-1:0] I_SW,
    input  logic [NPORT-1:0]   I_OE_n,
    output logic [W-1:0]       O_D,
    output logic               O_COIN
);

    localparam logic [NPORT*W-1:0] RST_ALL =
        (NPORT*W)'(stable_rst(32'(INV), NPORT, W));

    logic [W-1:0] stable [NPORT];
    logic [W-1:0] val    [NPORT];
    logic [W-1:0] rd     [NPORT];

    logic coin_act;
    logic coin_prev;
    logic coin_lat;
    logic oe_prev;

    generate
        for (genvar p = 0; p < NPORT; p++) begin : g_port
            dkong_debounce #(
                .W        (W),
                .DB_TICKS (DB_TICKS),
                .RST_VAL  (RST_ALL[p*W +: W])
            ) u_db (
                .clk    (I_CLK),
                .rst_n  (I_RST_n),
                .tick   (I_TICK),
                .sw     (I_SW[p*W +: W]),
                .stable (stable[p])
            );

            assign val[p] = INV[p] ? ~stable[p] : stable[p];

            // The coin bit reads as pending until the read that observes it ends.
            if (p == COIN_PORT) begin : g_coin_rd
                always_comb begin
                    rd[p]           = val[p];
                    rd[p][COIN_BIT] = coin_lat | coin_act;
                end
            end else begin : g_plain_rd
                assign rd[p] = val[p];
            end
        end
    endgenerate

    assign coin_act = val[COIN_PORT][COIN_BIT];

    // Clear only on the trailing edge of the read strobe; a new coin edge wins.
    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            coin_prev <= 1'b0;
            oe_prev   <= 1'b1;
            coin_lat  <= 1'b0;
        end else begin
            coin_prev <= coin_act;
            oe_prev   <= I_OE_n[COIN_PORT];
            if (coin_act && !coin_prev)
                coin_lat <= 1'b1;
            else if (I_OE_n[COIN_PORT] && !oe_prev)
                coin_lat <= 1'b0;
        end
    end

    assign O_COIN = coin_lat;

    always_comb begin
        O_D = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (!I_OE_n[p]) O_D = O_D | rd[p];
        end
    end

endmodule

// File: tb/tb_dkong_inport_gen.sv
// Bench for dkong_inport_gen with default parameters (4 ports x 8 bits, 4-tick debounce).
module tb_dkong_inport_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [31:0] sw;
    logic [3:0]  oe_n;
    logic [7:0]  o_d;
    logic        o_coin;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // Port3 is a DIP port (idle 0s), ports 0..2 are active-low (idle 1s).
    localparam logic [31:0] IDLE = {8'h00, 8'hFF, 8'hFF, 8'hFF};

    typedef struct {
        logic [31:0] sw;
        logic [3:0]  oe_n;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vecs[8];

    dkong_inport_gen dut (
        .I_CLK   (clk),
        .I_RST_n (rst_n),
        .I_TICK  (tick),
        .I_SW    (sw),
        .I_OE_n  (oe_n),
        .O_D     (o_d),
        .O_COIN  (o_coin)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, wanted finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1;
            clk_n(1);
            tick = 1'b0;
            clk_n(1);
        end
    endtask

    task automatic settle(input logic [31:0] v);
        sw = v;
        clk_n(3);
        tick_n(4);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, wanted %b", name, act, exp);
        end
    endtask

    // scoreboard: expectation queued when the enable is driven, popped once O_D settles
    task automatic read_port(input string name, input logic [3:0] oe, input logic [7:0] exp);
        logic [7:0] e;
        oe_n = oe;
        exp_q.push_back(exp);
        #2;
        e = exp_q.pop_front();
        n_checks++;
        if (o_d !== e) begin
            n_fail++;
            $display("FAIL %s: got O_D=%h, wanted %h (oe_n=%b)", name, o_d, e, oe);
        end
    endtask

    initial begin
        logic [7:0] r;

        vecs[0] = '{{8'h5A, 8'hFF, 8'hFF, 8'hFF}, 4'b0111, 8'h5A};
        vecs[1] = '{{8'h00, 8'hFF, 8'hFF, 8'h5A}, 4'b1110, 8'hA5};
        vecs[2] = '{{8'h00, 8'hFF, 8'hCF, 8'hFC}, 4'b1100, 8'h33};
        vecs[3] = '{{8'h00, 8'hFF, 8'hCF, 8'hFC}, 4'b1111, 8'h00};
        vecs[4] = '{{8'h00, 8'hFF, 8'h00, 8'hFF}, 4'b1101, 8'hFF};
        vecs[5] = '{{8'h00, 8'hFE, 8'hFF, 8'hFF}, 4'b1011, 8'h01};
        vecs[6] = '{{8'h08, 8'hFB, 8'hFD, 8'hFE}, 4'b0000, 8'h0F};
        vecs[7] = '{{8'h81, 8'hFF, 8'hFF, 8'h7E}, 4'b0110, 8'h81};

        // reset
        rst_n = 1'b0;
        tick  = 1'b0;
        sw    = '1;
        oe_n  = 4'b0000;
        clk_n(3);
        read_port("reset_d", 4'b0000, 8'h00);
        check_bit("reset_coin", o_coin, 1'b0);

        sw    = {8'hFF, 8'hFF, 8'hFF, 8'hFE};
        oe_n  = 4'b1111;
        rst_n = 1'b1;
        clk_n(2);
        tick_n(4);
        read_port("release_p0", 4'b1110, 8'h01);
        oe_n = 4'b1111;
        settle(IDLE);

        // table-driven vectors: polarity, multi-enable, no enable
        for (int i = 0; i < 8; i++) begin
            settle(vecs[i].sw);
            read_port($sformatf("vec%0d", i), vecs[i].oe_n, vecs[i].exp_d);
            oe_n = 4'b1111;
        end

        // random data through an inverted and a straight port
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom_range(0, 255));
            settle({r, 8'hFF, 8'hFF, ~r});
            read_port($sformatf("rnd%0d_p0", i), 4'b1110, r);
            read_port($sformatf("rnd%0d_p3", i), 4'b0111, r);
            oe_n = 4'b1111;
        end
        settle(IDLE);

        // bounce rejection on port1 bit4
        for (int k = 0; k < 3; k++) begin
            sw = {8'h00, 8'hFF, 8'hEF, 8'hFF};
            clk_n(3);
            tick_n(3);
            read_port("bounce_lo", 4'b1101, 8'h00);
            oe_n = 4'b1111;
            sw = IDLE;
            clk_n(3);
            tick_n(1);
            read_port("bounce_hi", 4'b1101, 8'h00);
            oe_n = 4'b1111;
        end
        sw = {8'h00, 8'hFF, 8'hEF, 8'hFF};
        clk_n(3);
        tick_n(3);
        read_port("hold_3ticks", 4'b1101, 8'h00);
        oe_n = 4'b1111;
        tick_n(1);
        read_port("hold_4ticks", 4'b1101, 8'h10);
        oe_n = 4'b1111;
        settle(IDLE);

        // coin latch set, hold, clear on end of read
        sw = {8'h00, 8'h7F, 8'hFF, 8'hFF};
        clk_n(3);
        tick_n(5);
        check_bit("coin_set", o_coin, 1'b1);
        sw = IDLE;
        clk_n(3);
        tick_n(4);
        check_bit("coin_held", o_coin, 1'b1);
        read_port("coin_rd", 4'b1011, 8'h80);
        clk_n(1);
        check_bit("coin_midread", o_coin, 1'b1);
        oe_n = 4'b1111;
        clk_n(1);
        check_bit("coin_clr", o_coin, 1'b0);
        read_port("coin_rd2", 4'b1011, 8'h00);
        oe_n = 4'b1111;
        clk_n(1);

        // new coin edge in the same cycle as the read ends
        sw = {8'h00, 8'h7F, 8'hFF, 8'hFF};
        clk_n(3);
        tick_n(4);
        sw = IDLE;
        clk_n(3);
        tick_n(4);
        read_port("sim_rd", 4'b1011, 8'h80);
        clk_n(1);
        sw = {8'h00, 8'h7F, 8'hFF, 8'hFF};
        clk_n(3);
        tick_n(3);
        tick = 1'b1;
        clk_n(1);
        tick = 1'b0;
        oe_n = 4'b1111;
        clk_n(1);
        check_bit("sim_setclr", o_coin, 1'b1);
        clk_n(1);
        check_bit("sim_hold", o_coin, 1'b1);
        sw = IDLE;
        clk_n(3);
        tick_n(4);
        read_port("sim_rd2", 4'b1011, 8'h80);
        clk_n(1);
        oe_n = 4'b1111;
        clk_n(1);
        check_bit("sim_clr", o_coin, 1'b0);

        // reset mid-read discards the latch
        sw = {8'h00, 8'h7F, 8'hFF, 8'hFF};
        clk_n(3);
        tick_n(4);
        sw = IDLE;
        clk_n(3);
        tick_n(4);
        check_bit("rst_pre", o_coin, 1'b1);
        oe_n = 4'b1011;
        clk_n(1);
        rst_n = 1'b0;
        clk_n(1);
        check_bit("rst_coin", o_coin, 1'b0);
        read_port("rst_d", 4'b1011, 8'h00);
        rst_n = 1'b1;
        oe_n  = 4'b1111;
        clk_n(2);
        check_bit("rst_after", o_coin, 1'b0);

        // reset mid-debounce discards the pending count
        sw = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        clk_n(3);
        tick_n(3);
        rst_n = 1'b0;
        clk_n(1);
        rst_n = 1'b1;
        clk_n(3);
        tick_n(3);
        read_port("rstdb_3ticks", 4'b0111, 8'h00);
        oe_n = 4'b1111;
        tick_n(1);
        read_port("rstdb_4ticks", 4'b0111, 8'hFF);
        oe_n = 4'b1111;

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
